binarize_pack_stream: RTL and testbench

Streaming successor to the single-pixel input binarizer. Accepts PIXELS_PER_BEAT unsigned pixels per valid/ready beat and binarizes each against a threshold. Packs the resulting bits LSB-first into OUTPUT_WIDTH-bit words for the first BNN fully-connected layer. Emits a full word when OUTPUT_WIDTH bits have been gathered, or a zero-padded partial word on in_last.

---
 rtl/binarize_pack_stream.sv | 137 +++++++++++++
 tb/tb_binarize_pack_stream.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/binarize_pack_stream.sv
// Streaming binarizer: thresholds PIXELS_PER_BEAT pixels per beat and packs the bits
// LSB-first into OUTPUT_WIDTH-bit words. Optional macro BINARIZE_THRESH_PROG_EN adds a runtime threshold.

module binarize_lane #(
    parameter int IDW = 8
) (
    input  logic [IDW-1:0] pix_i,
    input  logic [IDW-1:0] thr_i,
    output logic           bit_o
);
    assign bit_o = (pix_i >= thr_i);
endmodule

module binarize_pack_stream #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PIXELS_PER_BEAT  = 4,
    parameter int OUTPUT_WIDTH     = 16,
    parameter int THRESHOLD        = 128
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [PIXELS_PER_BEAT*INPUT_DATA_WIDTH-1:0] in_data,
    input  logic                                        in_last,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [OUTPUT_WIDTH-1:0]                     out_data,
    output logic [$clog2(OUTPUT_WIDTH+1)-1:0]           out_bits,
    output logic                                        out_last
`ifdef BINARIZE_THRESH_PROG_EN
    ,
    input  logic                                        thresh_wr,
    input  logic [INPUT_DATA_WIDTH-1:0]                 thresh_data
`endif
);
    localparam int IDW = INPUT_DATA_WIDTH;
    localparam int PPB = PIXELS_PER_BEAT;
    localparam int OW  = OUTPUT_WIDTH;
    localparam int CW  = $clog2(OW+1);
    localparam logic [CW-1:0] PPB_C = CW'(PPB);
    localparam logic [CW-1:0] OW_C  = CW'(OW);

    generate
        if (OW % PPB != 0) begin : g_bad_cfg
            $error("OUTPUT_WIDTH must be a multiple of PIXELS_PER_BEAT");
        end
    endgenerate

    logic [IDW-1:0] thr;
`ifdef BINARIZE_THRESH_PROG_EN
    logic [IDW-1:0] thr_q;
    // A beat accepted alongside thresh_wr still sees the old value in thr_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            thr_q <= IDW'(THRESHOLD);
        else if (thresh_wr) thr_q <= thresh_data;
    end
    assign thr = thr_q;
`else
    assign thr = IDW'(THRESHOLD);
`endif

    logic [PPB-1:0] beat_bits;
    genvar g;
    generate
        for (g = 0; g < PPB; g++) begin : g_lane
            binarize_lane #(.IDW(IDW)) u_lane (
                .pix_i (in_data[g*IDW +: IDW]),
                .thr_i (thr),
                .bit_o (beat_bits[g])
            );
        end
    endgenerate

    logic [OW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] odata_q, odata_d;
    logic [CW-1:0] obits_q, obits_d;
    logic          olast_q, olast_d;
    logic          ovld_q, ovld_d;

    logic          accept;
    logic [CW-1:0] cnt_nxt;
    logic [OW-1:0] merged;

    assign in_ready = !ovld_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_nxt  = cnt_q + PPB_C;
    // acc is always zero at and above cnt, so OR-merge leaves the upper bits clear.
    assign merged   = acc_q | (OW'(beat_bits) << cnt_q);

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        odata_d = odata_q;
        obits_d = obits_q;
        olast_d = olast_q;
        ovld_d  = ovld_q;
        if (ovld_q && out_ready) ovld_d = 1'b0;
        if (accept) begin
            if (cnt_nxt == OW_C || in_last) begin
                odata_d = merged;
                obits_d = cnt_nxt;
                olast_d = in_last;
                ovld_d  = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = merged;
                cnt_d = cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            odata_q <= '0;
            obits_q <= '0;
            olast_q <= 1'b0;
            ovld_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            odata_q <= odata_d;
            obits_q <= obits_d;
            olast_q <= olast_d;
            ovld_q  <= ovld_d;
        end
    end

    assign out_valid = ovld_q;
    assign out_data  = odata_q;
    assign out_bits  = obits_q;
    assign out_last  = olast_q;
endmodule

// File: tb/tb_binarize_pack_stream.sv
// Bench for binarize_pack_stream: directed plan cases plus random traffic against a
// bit-queue reference model. Define BINARIZE_THRESH_PROG_EN to cover the threshold port.

module tb_binarize_pack_stream;
    localparam int IDW = 8;
    localparam int PPB = 4;
    localparam int OW  = 16;
    localparam int THR = 128;
    localparam int BW  = $clog2(OW+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, in_last;
    logic [PPB*IDW-1:0] in_data;
    logic              out_valid, out_ready, out_last;
    logic [OW-1:0]     out_data;
    logic [BW-1:0]     out_bits;
    logic              thresh_wr;
    logic [IDW-1:0]    thresh_data;

    binarize_pack_stream #(
        .INPUT_DATA_WIDTH(IDW), .PIXELS_PER_BEAT(PPB), .OUTPUT_WIDTH(OW), .THRESHOLD(THR)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bits(out_bits), .out_last(out_last)
`ifdef BINARIZE_THRESH_PROG_EN
        , .thresh_wr(thresh_wr), .thresh_data(thresh_data)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct { logic [OW-1:0] d; int n; bit l; } word_t;
    bit             pend[$];
    word_t          expq[$];
    logic [IDW-1:0] mthr = IDW'(THR);

    logic [OW-1:0]  last_d;
    int             last_n;
    bit             last_l;
    int             words = 0;
    bit             acc_flag;
    bit             due_valid = 0;
    bit             hold_v = 0;
    logic [OW-1:0]  hold_d;
    logic [BW-1:0]  hold_n;
    logic           hold_l;

    // One clock: sample at negedge, update model/scoreboard, return 1ns after posedge.
    task automatic step();
        word_t w;
        @(negedge clk);
        acc_flag = 0;
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_in_ready",  32'(in_ready), 1);
            chk("rst_out_data",  32'(out_data), 0);
            chk("rst_out_bits",  32'(out_bits), 0);
            chk("rst_out_last",  32'(out_last), 0);
            pend.delete(); expq.delete();
            hold_v = 0; due_valid = 0;
            mthr = IDW'(THR);
        end else begin
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (due_valid) chk("latency_valid", 32'(out_valid), 1);
            if (hold_v) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data",  32'(out_data), 32'(hold_d));
                chk("hold_bits",  32'(out_bits), 32'(hold_n));
                chk("hold_last",  32'(out_last), 32'(hold_l));
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data; hold_n = out_bits; hold_l = out_last;
            due_valid = 0;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("spurious_word", 1, 0);
                else begin
                    w = expq.pop_front();
                    chk("word_data", 32'(out_data), 32'(w.d));
                    chk("word_bits", 32'(out_bits), 32'(w.n));
                    chk("word_last", 32'(out_last), 32'(w.l));
                end
                last_d = out_data; last_n = int'(out_bits); last_l = out_last;
                words++;
            end
            if (in_valid && in_ready) begin
                acc_flag = 1;
                for (int i = 0; i < PPB; i++) pend.push_back(in_data[i*IDW +: IDW] >= mthr);
                if (pend.size() == OW || in_last) begin
                    w.d = '0;
                    for (int k = 0; k < pend.size(); k++) w.d[k] = pend[k];
                    w.n = pend.size();
                    w.l = in_last;
                    expq.push_back(w);
                    pend.delete();
                    due_valid = 1;
                end
            end
`ifdef BINARIZE_THRESH_PROG_EN
            if (thresh_wr) mthr = thresh_data;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PPB*IDW-1:0] px(input int a, input int b, input int c, input int d);
        return {IDW'(d), IDW'(c), IDW'(b), IDW'(a)};
    endfunction

    int tries;
    task automatic send(input logic [PPB*IDW-1:0] d, input logic l);
        in_valid = 1; in_data = d; in_last = l;
        tries = 0;
        do begin
            step();
            tries++;
        end while (!acc_flag && tries < 50);
        if (!acc_flag) chk("send_timeout", 0, 1);
        in_valid = 0; in_last = 0; in_data = $urandom;
    endtask

    int w0;
    initial begin
        rst = 1; in_valid = 0; in_last = 0; in_data = '0; out_ready = 1;
        thresh_wr = 0; thresh_data = '0;
        #1;
        step(); step();
        rst = 0;
        step();

        // T1: {127,128,255,0} x4 -> 16'h6666
        w0 = words;
        for (int i = 0; i < 4; i++) begin
            send(px(127, 128, 255, 0), 0);
            chk("t1_no_stall", 32'(tries), 1);
        end
        step(); step();
        chk("t1_words", 32'(words - w0), 1);
        chk("t1_data", 32'(last_d), 32'h6666);
        chk("t1_bits", 32'(last_n), 16);
        chk("t1_last", 32'(last_l), 0);

        // T2: partial word on in_last
        send(px(255, 255, 255, 255), 0);
        send(px(255, 255, 255, 255), 1);
        step(); step();
        chk("t2_data", 32'(last_d), 32'h00FF);
        chk("t2_bits", 32'(last_n), 8);
        chk("t2_last", 32'(last_l), 1);

        // T3: backpressure for 5 cycles with a beat on offer
        out_ready = 0;
        for (int i = 0; i < 4; i++) send(px(200, 0, 0, 200), 0);
        in_valid = 1; in_data = px(0, 255, 0, 255); in_last = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_in_ready_low", 32'(in_ready), 0);
            chk("t3_no_accept", 32'(acc_flag), 0);
        end
        out_ready = 1;
        #1 chk("t3_in_ready_comb", 32'(in_ready), 1);
        step();
        chk("t3_accept_on_release", 32'(acc_flag), 1);
        chk("t3_data", 32'(last_d), 32'h9999);
        in_valid = 0; in_last = 0;
        step(); step();
        chk("t3_tail_data", 32'(last_d), 32'h000A);
        chk("t3_tail_bits", 32'(last_n), 4);

        // T4: 8 back-to-back beats -> two 16'h5555
        w0 = words;
        for (int i = 0; i < 8; i++) begin
            send(px(200, 10, 200, 10), 0);
            chk("t4_no_stall", 32'(tries), 1);
        end
        step(); step();
        chk("t4_words", 32'(words - w0), 2);
        chk("t4_data", 32'(last_d), 32'h5555);

        // T5: async reset while a word is stalled, then mid-image
        out_ready = 0;
        for (int i = 0; i < 4; i++) send(px(255, 0, 255, 0), 0);
        rst = 1;
        #1 chk("t5_async_clear", 32'(out_valid), 0);
        chk("t5_rst_in_ready", 32'(in_ready), 1);
        step();
        rst = 0; out_ready = 1;
        send(px(255, 255, 255, 255), 0);
        send(px(255, 255, 255, 255), 0);
        rst = 1; step(); rst = 0;
        w0 = words;
        for (int i = 0; i < 4; i++) send(px(0, 0, 0, 0), 0);
        step(); step();
        chk("t5_words", 32'(words - w0), 1);
        chk("t5_data", 32'(last_d), 32'h0000);
        chk("t5_bits", 32'(last_n), 16);

`ifdef BINARIZE_THRESH_PROG_EN
        // T6: beat in the write cycle uses old threshold
        thresh_wr = 1; thresh_data = 8'd64;
        send(px(100, 100, 100, 100), 0);
        thresh_wr = 0;
        send(px(64, 63, 100, 0), 1);
        step(); step();
        chk("t6_data", 32'(last_d), 32'h0050);
        chk("t6_bits", 32'(last_n), 8);
`endif

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < PPB; i++)
                in_data[i*IDW +: IDW] = IDW'(($urandom_range(0, 1) != 0) ? $urandom : THR - 2 + $urandom_range(0, 3));
            rst = ($urandom_range(0, 299) == 0);
`ifdef BINARIZE_THRESH_PROG_EN
            thresh_wr   = ($urandom_range(0, 49) == 0);
            thresh_data = IDW'($urandom);
`endif
            step();
        end
        rst = 0; thresh_wr = 0; out_ready = 1;
        send(px(1, 2, 3, 4), 1);
        for (int c = 0; c < 20 && expq.size() != 0; c++) step();
        chk("drain_empty", 32'(expq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
